// File: rtl/serial_subtractor_4.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - borrow_in, LSB first, one full-subtractor
// cell reused over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_borrow_out
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept_c;
  logic             last_bit_c;
  logic             d_bit_c;
  logic             br_next_c;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] bit_cnt;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d_bit_c   = a_sr[0] ^ b_sr[0] ^ br;
    br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a start is only honoured from IDLE or the DONE cycle
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_bit_c = (bit_cnt == LAST_BIT);
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept_c   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit_c) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          accept_c   = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs track the state being entered so they line up with it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_busy <= (state_next == ST_RUN);
      o_done <= (state_next == ST_DONE);
    end
  end

  // Datapath: capture on accept, shift while running, publish on the last bit only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      br           <= 1'b0;
      bit_cnt      <= '0;
      o_d          <= '0;
      o_borrow_out <= 1'b0;
    end else if (accept_c) begin
      a_sr    <= i_a;
      b_sr    <= i_b;
      res_sr  <= '0;
      br      <= i_borrow_in;
      bit_cnt <= '0;
    end else if (state == ST_RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= {d_bit_c, res_sr[WIDTH-1:1]};
      br      <= br_next_c;
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (last_bit_c) begin
        o_d          <= {d_bit_c, res_sr[WIDTH-1:1]};
        o_borrow_out <= br_next_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4.sv
// Self-checking bench for serial_subtractor_4: vector table, handshake timing,
// back-to-back, ignored mid-run start, and async reset abort.
module tb_serial_subtractor_4;

  localparam int unsigned WIDTH = 4;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_borrow_in;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_d;
  logic             o_borrow_out;

  serial_subtractor_4 #(.WIDTH(WIDTH)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_borrow_in  (i_borrow_in),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_d          (o_d),
    .o_borrow_out (o_borrow_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
  } vec_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] last_d   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result
  always @(negedge i_clk) begin
    if (i_rst_n && o_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_d", 32'(o_d), 32'(e.d));
        check("result_bout", 32'(o_borrow_out), 32'(e.bout));
      end
    end
  end

  // Issue one operation and check the handshake through its DONE cycle.
  // poke=1 pulses i_start with other operands in cycle 2, which must be ignored.
  // Returns at the falling edge inside the DONE cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b, input bit poke);
    exp_t e;
    i_a = a; i_b = b; i_borrow_in = bin; i_start = 1'b1;
    e.d = exp_d; e.bout = exp_b;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_a = WIDTH'($urandom); i_b = WIDTH'($urandom); i_borrow_in = 1'($urandom);
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge i_clk);
      check("busy_run", 32'(o_busy), 32'd1);
      check("done_run", 32'(o_done), 32'd0);
      check("d_held_run", 32'(o_d), 32'(last_d));
      if (poke && k == 2) begin
        i_start = 1'b1; i_a = WIDTH'(1); i_b = WIDTH'(1); i_borrow_in = 1'b0;
      end else begin
        i_start = 1'b0;
      end
    end
    @(negedge i_clk);
    check("done_pulse", 32'(o_done), 32'd1);
    check("busy_done", 32'(o_busy), 32'd0);
    last_d = exp_d;
  endtask

  task automatic idle_cycles(input int n);
    i_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_done", 32'(o_done), 32'd0);
      check("idle_d_held", 32'(o_d), 32'(last_d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{a: 4'b1010, b: 4'b0001, bin: 1'b0, d: 4'b1001, bout: 1'b0};
    vecs[1] = '{a: 4'b0011, b: 4'b0101, bin: 1'b0, d: 4'b1110, bout: 1'b1};
    vecs[2] = '{a: 4'b0000, b: 4'b0000, bin: 1'b1, d: 4'b1111, bout: 1'b1};
    vecs[3] = '{a: 4'b1111, b: 4'b1111, bin: 1'b1, d: 4'b1111, bout: 1'b1};
    vecs[4] = '{a: 4'b1111, b: 4'b0000, bin: 1'b0, d: 4'b1111, bout: 1'b0};
    vecs[5] = '{a: 4'b1000, b: 4'b1001, bin: 1'b0, d: 4'b1111, bout: 1'b1};
    vecs[6] = '{a: 4'b0101, b: 4'b0011, bin: 1'b1, d: 4'b0001, bout: 1'b0};
    vecs[7] = '{a: 4'b0110, b: 4'b0110, bin: 1'b0, d: 4'b0000, bout: 1'b0};

    i_rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_borrow_in = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_d", 32'(o_d), 32'd0);
    check("rst_bout", 32'(o_borrow_out), 32'd0);
    i_rst_n = 1'b1;
    idle_cycles(2);

    // Table of directed vectors, each followed by a return to idle
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, 1'b0);
      idle_cycles(1);
    end

    // Mid-run start ignored: one done only, from the first operands
    run_op(4'b1100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1);
    idle_cycles(WIDTH + 2);

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op(4'b1010, 4'b0001, 1'b0, 4'b1001, 1'b0, 1'b0);
    run_op(4'b0111, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);
    idle_cycles(1);

    // Async reset in cycle 2 aborts the operation
    i_a = 4'b1001; i_b = 4'b0011; i_borrow_in = 1'b0; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("pre_abort_busy", 32'(o_busy), 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_d", 32'(o_d), 32'd0);
    check("abort_bout", 32'(o_borrow_out), 32'd0);
    last_d = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_cycles(WIDTH + 3);
    run_op(4'b1001, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b0);

    // Random operations against an arithmetic model, sometimes back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rbin;
      logic [WIDTH:0]   r;
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
      r = {1'b0, ra} - {1'b0, rb} - (WIDTH + 1)'(rbin);
      run_op(ra, rb, rbin, r[WIDTH-1:0], r[WIDTH], 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(WIDTH + 2);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
